// File: rtl/prv32_timer_pkg.sv
// Shared definitions for the PRV32 machine-timer blocks.
//   - FSM state encoding for the mtimecmp update guard
//   - mtimecmp reset value
//   - default guard length, also used by the mtime integration glue
package prv32_timer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GUARD = 1'b1
    } tmr_state_e;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam int          GUARD_CYC    = 8;

endpackage

// File: rtl/cmp64_ge.sv
// Combinational 64-bit unsigned a >= b.
// The high halves are compared on their own; the low halves only matter
// when the high halves are equal. This keeps the critical path to two
// 32-bit comparators plus a small merge.
// Ports:
//   a  in  64  left operand
//   b  in  64  right operand
//   ge out 1   a >= b (unsigned)
module cmp64_ge (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        ge
);

    logic hi_gt;
    logic hi_eq;
    logic lo_ge;

    assign hi_gt = a[63:32] >  b[63:32];
    assign hi_eq = a[63:32] == b[63:32];
    assign lo_ge = a[31:0]  >= b[31:0];
    assign ge    = hi_gt | (hi_eq & lo_ge);

endmodule

// File: rtl/mtimecmp.sv
// Machine-timer compare register pair, interrupt generation and tear-free
// mtime read snapshot.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mtime_h, mtime_l    current mtime value (registered upstream)
//   wdata               write data for either compare half
//   wrh_n, wrl_n        active-low writes of mtimecmp[63:32] / [31:0]
//   rdl_n               active-low snapshot strobe (captures all 64 bits)
//   mtimecmph/l         compare register halves
//   snap_h/l            mtime snapshot halves
//   mtip                timer interrupt pending (registered level)
//   guard               high while interrupt is suppressed after a low write
module mtimecmp
    import prv32_timer_pkg::*;
#(
    parameter int GUARD_CYC = prv32_timer_pkg::GUARD_CYC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mtime_h,
    input  logic [31:0] mtime_l,
    input  logic [31:0] wdata,
    input  logic        wrh_n,
    input  logic        wrl_n,
    input  logic        rdl_n,
    output logic [31:0] mtimecmph,
    output logic [31:0] mtimecmpl,
    output logic [31:0] snap_h,
    output logic [31:0] snap_l,
    output logic        mtip,
    output logic        guard
);

    localparam logic [7:0] GUARD_RLD = 8'(GUARD_CYC - 1);

    tmr_state_e state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       hit;

    // Compare against the registered cmp value; a write in this cycle only
    // takes effect for the next compare.
    cmp64_ge u_ge (
        .a  ({mtime_h, mtime_l}),
        .b  ({mtimecmph, mtimecmpl}),
        .ge (hit)
    );

    // A lone low-half write opens (or extends) a guard window so software can
    // finish a low/high/low update without a spurious interrupt. Any high-half
    // write closes the window immediately.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (!wrl_n && wrh_n) begin
                    state_nxt = ST_GUARD;
                    cnt_nxt   = GUARD_RLD;
                end
            end
            ST_GUARD: begin
                if (!wrh_n) begin
                    state_nxt = ST_IDLE;
                end else if (!wrl_n) begin
                    cnt_nxt = GUARD_RLD;
                end else if (cnt == 8'd0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            mtimecmph <= MTIMECMP_RST[63:32];
            mtimecmpl <= MTIMECMP_RST[31:0];
            snap_h    <= 32'd0;
            snap_l    <= 32'd0;
            mtip      <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (!wrh_n) mtimecmph <= wdata;
            if (!wrl_n) mtimecmpl <= wdata;
            // Both halves on the same edge so a low->high carry cannot tear.
            if (!rdl_n) begin
                snap_h <= mtime_h;
                snap_l <= mtime_l;
            end
            // Pure level: recomputed every cycle, never held sticky.
            mtip <= hit && (state_nxt != ST_GUARD);
        end
    end

    assign guard = (state == ST_GUARD);

endmodule

// File: tb/tb_mtimecmp.sv
module tb_mtimecmp;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] mt;
    logic [31:0] wdata;
    logic        wrh_n, wrl_n, rdl_n;
    logic [31:0] mtimecmph, mtimecmpl, snap_h, snap_l;
    logic        mtip, guard;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mtimecmp #(.GUARD_CYC(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .mtime_h   (mt[63:32]),
        .mtime_l   (mt[31:0]),
        .wdata     (wdata),
        .wrh_n     (wrh_n),
        .wrl_n     (wrl_n),
        .rdl_n     (rdl_n),
        .mtimecmph (mtimecmph),
        .mtimecmpl (mtimecmpl),
        .snap_h    (snap_h),
        .snap_l    (snap_l),
        .mtip      (mtip),
        .guard     (guard)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // advance one edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // single-cycle strobe: hi/lo select which halves are written
    task automatic wr(input logic hi, input logic lo, input logic [31:0] d);
        wdata = d;
        wrh_n = ~hi;
        wrl_n = ~lo;
        tick();
        wrh_n = 1'b1;
        wrl_n = 1'b1;
    endtask

    initial begin
        rst = 1'b1; mt = 64'd5; wdata = '0;
        wrh_n = 1'b1; wrl_n = 1'b1; rdl_n = 1'b1;

        // reset
        tick(); tick();
        chk("rst_cmph", mtimecmph, 32'hFFFF_FFFF);
        chk("rst_cmpl", mtimecmpl, 32'hFFFF_FFFF);
        chk("rst_mtip", mtip, 0);
        chk("rst_guard", guard, 0);
        chk("rst_snap", {snap_h, snap_l}, 64'd0);
        rst = 1'b0;

        // basic fire: cmp = 100, mtime ramps from 90
        mt = 64'd90;
        wr(1, 0, 32'd0);
        wr(0, 1, 32'd100);
        chk("fire_cmp", {mtimecmph, mtimecmpl}, 64'd100);
        for (int v = 90; v < 100; v++) begin
            mt = 64'(v);
            tick();
            chk("fire_below", mtip, 0);
        end
        chk("fire_guard_done", guard, 0);
        mt = 64'd100; tick();
        chk("fire_eq", mtip, 1);
        mt = 64'd101; tick();
        chk("fire_hold", mtip, 1);
        mt = 64'd102;
        wr(1, 1, 32'h200);
        chk("fire_rewr_cmp", {mtimecmph, mtimecmpl}, 64'h0000_0200_0000_0200);
        chk("fire_prewrite_mtip", mtip, 1);
        chk("fire_rewr_guard", guard, 0);
        tick();
        chk("fire_drop", mtip, 0);

        // guard: cmp = 1_FFFFFFFF, then low = 0 makes cmp == mtime
        do_reset();
        mt = 64'h1_0000_0000;
        wr(1, 0, 32'd1);
        tick();
        chk("g_pre_mtip", mtip, 0);
        wr(0, 1, 32'd0);
        chk("g_cmp", {mtimecmph, mtimecmpl}, 64'h1_0000_0000);
        for (int i = 0; i < 8; i++) begin
            if (i != 0) tick();
            chk("g_guard_on", guard, 1);
            chk("g_mtip_off", mtip, 0);
        end
        tick();
        chk("g_guard_end", guard, 0);
        chk("g_mtip_fire", mtip, 1);

        // guard cut short by a high write 3 cycles in
        do_reset();
        wr(1, 0, 32'd1);
        wr(0, 1, 32'd0);
        chk("gh_guard", guard, 1);
        tick(); tick();
        chk("gh_guard2", guard, 1);
        wr(1, 0, 32'd2);
        chk("gh_guard_clr", guard, 0);
        chk("gh_cmp", {mtimecmph, mtimecmpl}, 64'h2_0000_0000);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("gh_mtip_off", mtip, 0);
            chk("gh_guard_off", guard, 0);
        end

        // simultaneous strobes: no guard, fires a cycle later
        do_reset();
        mt = 64'd5;
        wr(1, 1, 32'd0);
        chk("sim_guard", guard, 0);
        chk("sim_cmp", {mtimecmph, mtimecmpl}, 64'd0);
        chk("sim_mtip_pre", mtip, 0);
        tick();
        chk("sim_mtip", mtip, 1);

        // wrap: cmp = 5_00000005, mtime at max then 0
        wr(1, 1, 32'd5);
        mt = 64'hFFFF_FFFF_FFFF_FFFF;
        tick(); tick();
        chk("wrap_max", mtip, 1);
        mt = 64'd0; tick();
        chk("wrap_zero", mtip, 0);

        // snapshot across a carry
        mt = 64'h3_FFFF_FFFF;
        rdl_n = 1'b0; tick(); rdl_n = 1'b1;
        chk("snap_h", snap_h, 32'd3);
        chk("snap_l", snap_l, 32'hFFFF_FFFF);
        mt = 64'h4_0000_0000; tick();
        chk("snap_hold", {snap_h, snap_l}, 64'h3_FFFF_FFFF);
        rdl_n = 1'b0; tick(); rdl_n = 1'b1;
        chk("snap_new", {snap_h, snap_l}, 64'h4_0000_0000);

        // reset mid-guard (counter = 4)
        do_reset();
        mt = 64'hFFFF_FFFF_FFFF_FFFF;
        wr(0, 1, 32'd0);
        tick(); tick(); tick();
        chk("rg_guard", guard, 1);
        chk("rg_mtip", mtip, 0);
        rst = 1'b1; wrl_n = 1'b0; wdata = 32'd7;
        tick();
        chk("rg_rst_guard", guard, 0);
        chk("rg_rst_cmp", {mtimecmph, mtimecmpl}, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rg_rst_mtip", mtip, 0);
        rst = 1'b0; wrl_n = 1'b1;
        tick();
        chk("rg_after_guard", guard, 0);
        chk("rg_after_mtip", mtip, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
